// File: rtl/game_pkg.sv
// Shared definitions for the game datapath: one-hot direction codes and the
// input-stage FSM states.
package game_pkg;

  localparam logic [3:0] DIR_NONE  = 4'b0000;
  localparam logic [3:0] DIR_RIGHT = 4'b0001;
  localparam logic [3:0] DIR_DOWN  = 4'b0010;
  localparam logic [3:0] DIR_UP    = 4'b0100;
  localparam logic [3:0] DIR_LEFT  = 4'b1000;

  typedef enum logic {
    IDLE,
    LOCKED
  } in_state_t;

  // True when exactly one button is down; several at once must not move the snake.
  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button channel: two-flop synchroniser followed by a consecutive-sample
// debounce counter that accepts a new level only after it has persisted.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic stable
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Any sample that agrees with the current level restarts the count, so a
  // bounce resets the wait rather than merely pausing it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count  <= '0;
      stable <= 1'b0;
    end else if (sync2 == stable) begin
      count <= '0;
    end else if (count == CNT_MAX) begin
      stable <= sync2;
      count  <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/direction_input.sv
// Front end of game_logic: turns four raw push-buttons into a single-cycle
// one-hot direction pulse, at most one per press-and-release-all sequence.
module direction_input
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int BTN_ACTIVE_LOW  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn_raw,
  output logic [3:0] direction,
  output logic [3:0] btn_stable,
  output logic       locked
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

  logic [3:0] btn_act;
  in_state_t  state;
  in_state_t  state_next;
  logic [3:0] dir_next;
  logic       locked_next;

  assign btn_act = (BTN_ACTIVE_LOW != 0) ? ~btn_raw : btn_raw;

  for (genvar i = 0; i < 4; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_debounce (
      .clk   (clk),
      .rst   (rst),
      .raw   (btn_act[i]),
      .stable(btn_stable[i])
    );
  end

  // Simultaneous accepts still lock, so a chord cannot sneak out a move later
  // when one of its buttons is released first.
  always_comb begin
    state_next = state;
    dir_next   = DIR_NONE;
    case (state)
      IDLE: begin
        if (btn_stable != DIR_NONE) begin
          state_next = LOCKED;
          if (is_onehot(btn_stable)) begin
            dir_next = btn_stable;
          end
        end
      end
      LOCKED: begin
        if (btn_stable == DIR_NONE) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    locked_next = (state_next == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      direction <= DIR_NONE;
      locked    <= 1'b0;
    end else begin
      state     <= state_next;
      direction <= dir_next;
      locked    <= locked_next;
    end
  end

endmodule

// File: tb/tb_direction_input.sv
// Bench for direction_input: active-high and active-low instances driven with the
// same logical buttons, compared every cycle against a run-length reference model.
module tb_direction_input;

  localparam int DEB = 4;

  logic       clk;
  logic       rst;
  logic [3:0] btn;
  logic [3:0] btn_n;
  logic [3:0] dir_h, stab_h, dir_l, stab_l;
  logic       lock_h, lock_l;

  int tests;
  int fails;

  // reference model state
  logic [3:0] m_pipe1, m_pipe2, m_stab, m_dir;
  logic       m_lock;
  int         m_run[4];
  logic [3:0] prev_dir_h;

  assign btn_n = ~btn;

  direction_input #(.DEBOUNCE_CYCLES(DEB), .BTN_ACTIVE_LOW(0)) dut_high (
    .clk(clk), .rst(rst), .btn_raw(btn),
    .direction(dir_h), .btn_stable(stab_h), .locked(lock_h)
  );

  direction_input #(.DEBOUNCE_CYCLES(DEB), .BTN_ACTIVE_LOW(1)) dut_low (
    .clk(clk), .rst(rst), .btn_raw(btn_n),
    .direction(dir_l), .btn_stable(stab_l), .locked(lock_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s at %0t: got %b, expected %b", tag, $time, obs, exp);
    end
  endtask

  // A level reaches the debouncer two edges after it is sampled and is accepted
  // once it has been seen on DEB consecutive edges; the FSM reacts one edge later.
  task automatic modelEdge(input logic [3:0] b, input logic r);
    logic [3:0] old_stab;
    if (!r) begin
      m_pipe1 = '0; m_pipe2 = '0; m_stab = '0; m_dir = '0; m_lock = 1'b0;
      for (int i = 0; i < 4; i++) m_run[i] = 0;
    end else begin
      old_stab = m_stab;
      for (int i = 0; i < 4; i++) begin
        if (m_pipe2[i] != m_stab[i]) begin
          m_run[i]++;
          if (m_run[i] == DEB) begin
            m_stab[i] = m_pipe2[i];
            m_run[i]  = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_dir  = (!m_lock && $countones(old_stab) == 1) ? old_stab : 4'b0000;
      m_lock = (old_stab != 4'b0000);
      m_pipe2 = m_pipe1;
      m_pipe1 = b;
    end
  endtask

  task automatic applyStimulus(input logic [3:0] b, input logic r);
    btn = b;
    rst = r;
    @(posedge clk);
    modelEdge(b, r);
    #1;
    checkOutput("dir_high",    dir_h,  m_dir);
    checkOutput("stable_high", stab_h, m_stab);
    checkOutput("locked_high", {3'b000, lock_h}, {3'b000, m_lock});
    checkOutput("dir_low",     dir_l,  m_dir);
    checkOutput("stable_low",  stab_l, m_stab);
    checkOutput("locked_low",  {3'b000, lock_l}, {3'b000, m_lock});
    checkOutput("dir_onehot",  {3'b000, ($countones(dir_h) > 1)}, 4'b0000);
    checkOutput("dir_no_repeat", {3'b000, (prev_dir_h != 4'b0000 && dir_h != 4'b0000)}, 4'b0000);
    prev_dir_h = dir_h;
  endtask

  task automatic holdFor(input logic [3:0] b, input int n);
    for (int i = 0; i < n; i++) applyStimulus(b, 1'b1);
  endtask

  initial begin
    logic [3:0] pat;
    int         sel;
    tests = 0;
    fails = 0;
    prev_dir_h = '0;
    btn = '0;
    rst = 1'b0;
    modelEdge('0, 1'b0);

    applyStimulus(4'b0000, 1'b0);
    applyStimulus(4'b0000, 1'b0);
    checkOutput("reset_dir",    dir_h,  4'b0000);
    checkOutput("reset_stable", stab_h, 4'b0000);
    checkOutput("reset_locked", {3'b000, lock_h}, 4'b0000);
    holdFor(4'b0000, 3);

    // clean press of right: pulse visible only after the seventh edge
    for (int i = 1; i <= 20; i++) begin
      applyStimulus(4'b0001, 1'b1);
      checkOutput("latency_dir", dir_h, (i == 7) ? 4'b0001 : 4'b0000);
      if (i == 6) checkOutput("latency_stable", stab_h, 4'b0001);
    end
    checkOutput("held_locked", {3'b000, lock_h}, 4'b0001);
    holdFor(4'b0000, 10);
    checkOutput("released_locked", {3'b000, lock_h}, 4'b0000);

    // bounce on left, then steady
    applyStimulus(4'b1000, 1'b1);
    applyStimulus(4'b0000, 1'b1);
    applyStimulus(4'b1000, 1'b1);
    applyStimulus(4'b0000, 1'b1);
    holdFor(4'b1000, 15);
    holdFor(4'b0000, 10);

    // up held, down added while locked, then down alone
    holdFor(4'b0100, 10);
    holdFor(4'b0110, 10);
    holdFor(4'b0000, 10);
    holdFor(4'b0010, 10);
    holdFor(4'b0000, 10);

    // simultaneous chord
    holdFor(4'b0011, 12);
    checkOutput("chord_locked", {3'b000, lock_h}, 4'b0001);
    holdFor(4'b0000, 10);

    // reset in the middle of a debounce with the button still held
    holdFor(4'b0001, 4);
    applyStimulus(4'b0001, 1'b0);
    checkOutput("midreset_dir",    dir_h,  4'b0000);
    checkOutput("midreset_stable", stab_h, 4'b0000);
    holdFor(4'b0001, 15);
    holdFor(4'b0000, 10);

    // randomized segments of held patterns, glitches and occasional resets
    for (int s = 0; s < 300; s++) begin
      sel = $urandom_range(0, 99);
      if (sel < 35)      pat = 4'b0000;
      else if (sel < 80) pat = 4'b0001 << $urandom_range(0, 3);
      else               pat = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 99) < 3) applyStimulus(pat, 1'b0);
      holdFor(pat, $urandom_range(1, 9));
    end
    holdFor(4'b0000, 10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
